// File: rtl/risc_pkg.sv
// Shared RISC-V decode definitions: opcode constants, issue-stage state
// encoding and operand-use helpers for hazard detection.
package risc_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ID_IDLE,
    ID_HELD,
    ID_DRAIN
  } id_state_e;

  // R/S/B read both sources; I-type (load, ALU-immediate, JALR) reads rs1 only.
  function automatic logic op_uses_rs1(input logic [6:0] op);
    return (op == OPCODE_OP)     || (op == OPCODE_STORE) ||
           (op == OPCODE_BRANCH) || (op == OPCODE_LOAD)  ||
           (op == OPCODE_OP_IMM) || (op == OPCODE_JALR);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OPCODE_OP) || (op == OPCODE_STORE) || (op == OPCODE_BRANCH);
  endfunction

  // R/I/U/J write rd; stores, branches, FENCE and SYSTEM do not.
  function automatic logic op_writes_rd(input logic [6:0] op);
    return (op == OPCODE_OP)     || (op == OPCODE_LOAD)  ||
           (op == OPCODE_OP_IMM) || (op == OPCODE_JALR)  ||
           (op == OPCODE_LUI)    || (op == OPCODE_AUIPC) ||
           (op == OPCODE_JAL);
  endfunction

  function automatic logic op_is_serialising(input logic [6:0] op);
    return (op == OPCODE_FENCE) || (op == OPCODE_SYSTEM);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// A set and a clear of the same register in one cycle leaves it busy,
// since the set belongs to a newer load than the completing writeback.
module id_scoreboard
  import risc_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_rd,
  output logic [NREGS-1:0]     busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear first, then set so the set wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    if (set_en) busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue controller between IF and EX. Holds one instruction in the IF/ID
// register and stalls it while a source or destination register has a
// load in flight. FENCE/SYSTEM wait until every outstanding load drains.
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. valid never depends on ready on the same side; once ex_valid_o is
// raised the held instruction and PC stay constant until it is taken or
// flushed. A flush drops valid and ready for that cycle.
module id_issue_ctrl
  import risc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [XLEN-1:0]  if_instr_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  ex_instr_o,
  output logic [XLEN-1:0]  ex_pc_o,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  output logic [NREGS-1:0] busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  id_state_e        state_q, state_d;
  logic [XLEN-1:0]  ex_instr_q, ex_instr_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NREGS-1:0] busy;

  logic                 fire_if;
  logic                 fire_ex;
  logic                 hazard;
  logic                 ex_valid;
  logic                 if_ready;
  logic [6:0]           held_op;
  logic [REG_IDX_W-1:0] held_rd;
  logic [REG_IDX_W-1:0] held_rs1;
  logic [REG_IDX_W-1:0] held_rs2;
  logic                 sb_set_en;

  assign held_op  = ex_instr_q[6:0];
  assign held_rd  = ex_instr_q[11:7];
  assign held_rs1 = ex_instr_q[19:15];
  assign held_rs2 = ex_instr_q[24:20];

  // RAW/WAW check of the held instruction against registered busy bits only.
  always_comb begin
    hazard = 1'b0;
    if (op_uses_rs1(held_op)  && busy[held_rs1]) hazard = 1'b1;
    if (op_uses_rs2(held_op)  && busy[held_rs2]) hazard = 1'b1;
    if (op_writes_rd(held_op) && busy[held_rd])  hazard = 1'b1;
  end

  // Issue validity per state, then both handshakes; flush suppresses both.
  always_comb begin
    ex_valid = 1'b0;
    case (state_q)
      ID_HELD:  ex_valid = ~hazard & ~flush_i;
      ID_DRAIN: ex_valid = (busy == '0) & ~flush_i;
      default:  ex_valid = 1'b0;
    endcase
    fire_ex  = ex_valid & ex_ready_i;
    if_ready = ~flush_i & ((state_q == ID_IDLE) | fire_ex);
    fire_if  = if_valid_i & if_ready;
  end

  // FSM next state: flush first, then a new accept, then a plain issue.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ID_IDLE;
    end else if (fire_if) begin
      state_d = op_is_serialising(if_instr_i[6:0]) ? ID_DRAIN : ID_HELD;
    end else if (fire_ex) begin
      state_d = ID_IDLE;
    end
  end

  // IF/ID register loads only on an accepted fetch.
  always_comb begin
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    if (fire_if) begin
      ex_instr_d = if_instr_i;
      ex_pc_d    = if_pc_i;
    end
  end

  // Count cycles an instruction is held but blocked, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ID_IDLE) && !ex_valid && !flush_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State, IF/ID and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ID_IDLE;
      ex_instr_q  <= '0;
      ex_pc_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_instr_q  <= ex_instr_d;
      ex_pc_q     <= ex_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A load marks its destination busy as it leaves for EX.
  assign sb_set_en = fire_ex && (held_op == OPCODE_LOAD) && (held_rd != '0);

  id_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (sb_set_en),
    .set_rd (held_rd),
    .clr_en (wb_valid_i),
    .clr_rd (wb_rd_i),
    .busy   (busy)
  );

  assign if_ready_o  = if_ready;
  assign ex_valid_o  = ex_valid;
  assign ex_instr_o  = ex_instr_q;
  assign ex_pc_o     = ex_pc_q;
  assign busy_o      = busy;
  assign stall_cnt_o = stall_cnt_q;

endmodule
